cu_edge_cacheline_unpack: RTL and testbench
===========================================

Name: cu_edge_cacheline_unpack

Overview:
- Downstream consumer of edge-array read responses for the PageRank CSR PULL compute unit.
- Accepts one edge job: byte start address plus edge count.
- Accepts the 128-byte cachelines returned for that job and unpacks them into a stream of 32-bit edge IDs, one per cycle, with a last flag.
- Start offset inside the first line uses the 128-byte modulo alignment. Trailing unused slots in the final line are discarded.

Parameters:
- CACHELINE_BYTES, 128, bytes per returned line.
- EDGE_BYTES, 4, bytes per edge ID.
- EDGE_BITS, EDGE_BYTES*8, edge ID width.
- SLOTS, CACHELINE_BYTES/EDGE_BYTES (32), edges per line.
- COUNT_BITS, 32, edge count width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- job_valid  in  1  job offered.
- job_ready  out  1  job accepted when job_valid && job_ready.
- job_start_addr  in  64  byte address of the first edge.
- job_edge_count  in  COUNT_BITS  number of edges to emit.
- line_valid  in  1  response cacheline offered.
- line_ready  out  1  line accepted when line_valid && line_ready.
- line_data  in  CACHELINE_BYTES*8  line payload; slot k = line_data[EDGE_BITS*k +: EDGE_BITS].
- edge_valid  out  1  edge output valid.
- edge_ready  in  1  consumer accepts the edge.
- edge_id  out  EDGE_BITS  unpacked edge ID.
- edge_last  out  1  final edge of the job.
- job_done  out  1  one-cycle pulse when the job completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: job_ready=0, line_ready=0, edge_valid=0, edge_id=0, edge_last=0, job_done=0, busy=0. State=IDLE, all counters and the line register cleared.
- Reset asserted mid-job aborts the job immediately. Any held line and partial output are discarded and nothing is replayed.
- States: IDLE, WAIT_LINE, EMIT, DONE.
- IDLE:
  - job_ready=1.
  - On accept: remaining=job_edge_count, slot_ptr=(job_start_addr & 0x7F)>>2 (bits [1:0] ignored).
  - If job_edge_count==0, go to DONE; otherwise go to WAIT_LINE.
- WAIT_LINE:
  - line_ready=1.
  - On accept: latch line_data, go to EMIT.
  - edge_valid rises the next cycle (1-cycle latency from line handshake).
- EMIT:
  - edge_valid=1, edge_id=slot[slot_ptr], edge_last=(remaining==1).
  - Outputs stay stable while edge_valid && !edge_ready.
  - On handshake: remaining-=1, slot_ptr+=1.
    - If remaining becomes 0, go to DONE.
    - Else if slot_ptr was SLOTS-1, slot_ptr wraps to 0 and the state goes to WAIT_LINE.
    - Otherwise stay in EMIT.
  - Back-to-back handshakes produce one edge per cycle within a line. Each line boundary costs at least 1 bubble cycle.
- DONE: job_done=1 for exactly one cycle, then IDLE. The next job can be accepted the following cycle.
- Lines consumed per job = ceil((offset+count)/SLOTS). No line is accepted after remaining reaches 0.
- Arithmetic:
  - remaining and slot_ptr are unsigned.
  - slot_ptr is $clog2(SLOTS) bits and wraps naturally.
  - remaining never underflows; it only decrements in EMIT with remaining>=1.
- Simultaneous events:
  - job_valid is ignored outside IDLE.
  - line_valid is ignored outside WAIT_LINE; the line must be held by the source.
- busy=1 from the cycle after job accept until the cycle job_done pulses (inclusive).

Optional Feature:
- Macro: EDGE_UNPACK_BYTE_SWAP_EN.
- Defined: each EDGE_BITS slot is byte-reversed before driving edge_id. Input 0x78563412 yields edge_id 0x12345678; this converts host big-endian words.
- Undefined: slot bits pass through unchanged.
- Timing and handshakes are identical in both builds.

Test Plan:
- Aligned single line: start_addr=0x1000, count=4, line slots 0..3 = 10,11,12,13, edge_ready=1 → edges 10,11,12,13 on consecutive cycles; edge_last only on 13; job_done 1 cycle later; exactly one line accepted.
- Offset crossing a line: start_addr=0x1078 (slot 30), count=5 → slots 30,31 of line A, then 0,1,2 of line B. 2 lines consumed, one bubble between the 2nd and 3rd edges, edge_last on B slot 2.
- Zero count: count=0 → no line_ready, no edge_valid, job_done pulses in the cycle after acceptance, job_ready high the cycle after that.
- Backpressure: count=3, edge_ready toggled 0,0,1,0,1,1 → edge_id/edge_last stable while stalled; exactly 3 handshakes; remaining reaches 0.
- Reset mid-job: count=64, assert reset after 10 edges → all outputs 0 asynchronously; after release, a new job count=1 emits correctly from a fresh line.
- Byte swap build: slot 0 = 0xAABBCCDD, count=1 → edge_id 0xDDCCBBAA with the macro defined, 0xAABBCCDD without it.

Source files
------------

// File: rtl/cu_edge_cacheline_unpack_if.sv
// Handshake bundle between the edge-fetch path and the cacheline unpacker.
// Carries the job request, the returned cacheline, the unpacked edge stream and status.
// master drives jobs/lines and edge_ready; slave is the unpacker side.
interface cu_edge_cacheline_unpack_if #(
    parameter int CACHELINE_BYTES = 128,
    parameter int EDGE_BYTES      = 4,
    parameter int COUNT_BITS      = 32
);
    localparam int EDGE_BITS = EDGE_BYTES * 8;

    logic                         job_valid;
    logic                         job_ready;
    logic [63:0]                  job_start_addr;
    logic [COUNT_BITS-1:0]        job_edge_count;
    logic                         line_valid;
    logic                         line_ready;
    logic [CACHELINE_BYTES*8-1:0] line_data;
    logic                         edge_valid;
    logic                         edge_ready;
    logic [EDGE_BITS-1:0]         edge_id;
    logic                         edge_last;
    logic                         job_done;
    logic                         busy;

    modport master (
        output job_valid, job_start_addr, job_edge_count, line_valid, line_data, edge_ready,
        input  job_ready, line_ready, edge_valid, edge_id, edge_last, job_done, busy
    );

    modport slave (
        input  job_valid, job_start_addr, job_edge_count, line_valid, line_data, edge_ready,
        output job_ready, line_ready, edge_valid, edge_id, edge_last, job_done, busy
    );
endinterface

// File: rtl/cu_edge_cacheline_unpack.sv
// Unpacks 128-byte edge-array cachelines of one job into a stream of 32-bit edge IDs.
// Latency: first edge 1 cycle after line accept; 1 edge/cycle within a line, >=1 bubble per line boundary.
// Backpressure: edge outputs hold while edge_ready is low; a line is only taken in WAIT_LINE.
// Ports: clock/reset (async, active-high) plus bus (slave modport): job_*, line_*, edge_*, job_done, busy.
// Optional macro EDGE_UNPACK_BYTE_SWAP_EN: byte-reverse each edge slot before output.
module cu_edge_cacheline_unpack #(
    parameter int CACHELINE_BYTES = 128,
    parameter int EDGE_BYTES      = 4,
    parameter int COUNT_BITS      = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    cu_edge_cacheline_unpack_if.slave   bus
);
    localparam int EDGE_BITS = EDGE_BYTES * 8;
    localparam int SLOTS     = CACHELINE_BYTES / EDGE_BYTES;
    localparam int PTR_BITS  = $clog2(SLOTS);
    localparam int OFF_LO    = $clog2(EDGE_BYTES);
    localparam int OFF_HI    = $clog2(CACHELINE_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, EMIT, DONE} state_t;

    state_t                       state_q, state_d;
    logic [COUNT_BITS-1:0]        remaining_q, remaining_d;
    logic [PTR_BITS-1:0]          slot_ptr_q, slot_ptr_d;
    logic [CACHELINE_BYTES*8-1:0] line_q, line_d;
    logic                         job_ready_q, job_ready_d;
    logic                         line_ready_q, line_ready_d;
    logic                         edge_valid_q, edge_valid_d;
    logic [EDGE_BITS-1:0]         edge_id_q, edge_id_d;
    logic                         edge_last_q, edge_last_d;
    logic                         job_done_q, job_done_d;
    logic                         busy_q, busy_d;
    logic [EDGE_BITS-1:0]         slot_word;

    // Only the in-line edge offset of the start address matters.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.job_start_addr[63:OFF_HI], bus.job_start_addr[OFF_LO-1:0]};

    function automatic logic [EDGE_BITS-1:0] fmt_edge(input logic [EDGE_BITS-1:0] w);
        logic [EDGE_BITS-1:0] r;
`ifdef EDGE_UNPACK_BYTE_SWAP_EN
        r = '0;
        for (int b = 0; b < EDGE_BYTES; b++) begin
            r[b*8 +: 8] = w[(EDGE_BYTES-1-b)*8 +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        slot_ptr_d  = slot_ptr_q;
        line_d      = line_q;
        case (state_q)
            IDLE: begin
                // job_ready_q gates the accept so the first cycle out of reset takes nothing.
                if (bus.job_valid && job_ready_q) begin
                    remaining_d = bus.job_edge_count;
                    slot_ptr_d  = bus.job_start_addr[OFF_HI-1:OFF_LO];
                    state_d     = (bus.job_edge_count == '0) ? DONE : WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (bus.line_valid && line_ready_q) begin
                    line_d  = bus.line_data;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (edge_valid_q && bus.edge_ready) begin
                    remaining_d = remaining_q - COUNT_BITS'(1);
                    slot_ptr_d  = slot_ptr_q + PTR_BITS'(1);
                    if (remaining_q == COUNT_BITS'(1)) begin
                        state_d = DONE;
                    end else if (slot_ptr_q == PTR_BITS'(SLOTS-1)) begin
                        state_d = WAIT_LINE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always describe state_q.
    always_comb begin
        slot_word    = line_d[slot_ptr_d*EDGE_BITS +: EDGE_BITS];
        job_ready_d  = (state_d == IDLE);
        line_ready_d = (state_d == WAIT_LINE);
        edge_valid_d = (state_d == EMIT);
        edge_id_d    = (state_d == EMIT) ? fmt_edge(slot_word) : edge_id_q;
        edge_last_d  = (state_d == EMIT) && (remaining_d == COUNT_BITS'(1));
        job_done_d   = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            slot_ptr_q   <= '0;
            line_q       <= '0;
            job_ready_q  <= 1'b0;
            line_ready_q <= 1'b0;
            edge_valid_q <= 1'b0;
            edge_id_q    <= '0;
            edge_last_q  <= 1'b0;
            job_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            slot_ptr_q   <= slot_ptr_d;
            line_q       <= line_d;
            job_ready_q  <= job_ready_d;
            line_ready_q <= line_ready_d;
            edge_valid_q <= edge_valid_d;
            edge_id_q    <= edge_id_d;
            edge_last_q  <= edge_last_d;
            job_done_q   <= job_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.job_ready  = job_ready_q;
    assign bus.line_ready = line_ready_q;
    assign bus.edge_valid = edge_valid_q;
    assign bus.edge_id    = edge_id_q;
    assign bus.edge_last  = edge_last_q;
    assign bus.job_done   = job_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cu_edge_cacheline_unpack.sv
// Bench for the cacheline unpacker: table vectors, hand-written corner sequences and
// random jobs, all checked against an address-arithmetic model of the edge stream.
module tb_cu_edge_cacheline_unpack;
    typedef logic [1023:0] line_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] cnt;
        bit          rnd;
        int          exp_lines;
    } vec_t;

    logic clock = 0;
    logic reset = 1;
    always #5 clock = ~clock;

    cu_edge_cacheline_unpack_if #(.CACHELINE_BYTES(128), .EDGE_BYTES(4), .COUNT_BITS(32)) bus ();

    cu_edge_cacheline_unpack #(.CACHELINE_BYTES(128), .EDGE_BYTES(4), .COUNT_BITS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    line_t       lines[$];
    int          ready_pat[$];
    bit          rand_ready;
    logic [31:0] got_id[$];
    bit          got_last[$];
    int          got_cyc[$];
    int          lines_taken, done_cnt, acc_cyc, done_cyc, proto_err, stall_err, ev_seen, lr_seen;
    bit          timed_out;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic make_lines(input int n, input bit pattern);
        line_t l;
        lines.delete();
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 32; k++)
                l[k*32 +: 32] = pattern ? 32'(10 + j*32 + k) : $urandom;
            lines.push_back(l);
        end
    endtask

    // Edge i of a job starting at in-line slot 'off' is global slot off+i of the line sequence.
    function automatic logic [31:0] model_edge(input int off, input int i);
        int          g;
        line_t       l;
        logic [31:0] w;
        g = off + i;
        l = lines[g / 32];
        w = l[(g % 32) * 32 +: 32];
`ifdef EDGE_UNPACK_BYTE_SWAP_EN
        w = {<<8{w}};
`endif
        return w;
    endfunction

    task automatic run_job(input logic [63:0] addr, input logic [31:0] cnt, input int abort_after);
        int          cyc, budget;
        bit          accepted, stalled;
        logic [31:0] prev_id;
        logic        prev_last;
        got_id.delete(); got_last.delete(); got_cyc.delete();
        lines_taken = 0; done_cnt = 0; acc_cyc = -1; done_cyc = -1;
        proto_err = 0; stall_err = 0; ev_seen = 0; lr_seen = 0; timed_out = 0;
        accepted = 0; stalled = 0; prev_id = '0; prev_last = 0; cyc = 0;
        budget = 200 + 8 * int'(cnt);
        @(negedge clock);
        bus.job_valid = 1; bus.job_start_addr = addr; bus.job_edge_count = cnt;
        while (1) begin
            if (cyc > budget) begin timed_out = 1; break; end
            if (bus.edge_valid && ready_pat.size() > 0) bus.edge_ready = (ready_pat.pop_front() != 0);
            else if (rand_ready) bus.edge_ready = 1'($urandom_range(0, 1));
            else bus.edge_ready = 1;
            bus.line_valid = (lines_taken < lines.size());
            bus.line_data  = bus.line_valid ? lines[lines_taken] : '0;
            #1;
            if (stalled && (!bus.edge_valid || bus.edge_id !== prev_id || bus.edge_last !== prev_last))
                stall_err++;
            if (bus.busy && bus.job_ready) proto_err++;
            if (bus.line_ready && bus.edge_valid) proto_err++;
            if (accepted && done_cnt == 0 && !bus.busy) proto_err++;
            if (bus.job_done && !bus.busy) proto_err++;
            if (bus.edge_valid) ev_seen++;
            if (bus.line_ready) lr_seen++;
            if (!accepted && bus.job_valid && bus.job_ready) begin accepted = 1; acc_cyc = cyc; end
            if (bus.line_valid && bus.line_ready) lines_taken++;
            if (bus.edge_valid && bus.edge_ready) begin
                got_id.push_back(bus.edge_id);
                got_last.push_back(bus.edge_last);
                got_cyc.push_back(cyc);
            end
            stalled   = bus.edge_valid && !bus.edge_ready;
            prev_id   = bus.edge_id;
            prev_last = bus.edge_last;
            if (bus.job_done) begin done_cnt++; done_cyc = cyc; break; end
            if (abort_after > 0 && got_id.size() >= abort_after) break;
            @(negedge clock);
            cyc++;
            if (accepted) bus.job_valid = 0;
        end
        bus.job_valid = 0;
        bus.line_valid = 0;
    endtask

    task automatic check_job(input string tag, input logic [63:0] addr, input logic [31:0] cnt,
                             input int exp_lines);
        int off, bad_val, bad_last, first_bad;
        off = int'(addr[6:2]);
        bad_val = 0; bad_last = 0; first_bad = -1;
        check({tag, "_edge_count"}, 64'(got_id.size()), 64'(cnt));
        for (int i = 0; i < got_id.size() && i < int'(cnt); i++) begin
            if (got_id[i] !== model_edge(off, i)) begin
                bad_val++;
                if (first_bad < 0) first_bad = i;
            end
            if (got_last[i] !== (i == int'(cnt) - 1)) bad_last++;
        end
        if (first_bad >= 0)
            $display("  %s first wrong edge index %0d: got %0h", tag, first_bad, got_id[first_bad]);
        check({tag, "_edge_vals_bad"}, 64'(bad_val), 64'd0);
        check({tag, "_edge_last_bad"}, 64'(bad_last), 64'd0);
        check({tag, "_lines_taken"}, 64'(lines_taken), 64'(exp_lines));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_stall_unstable"}, 64'(stall_err), 64'd0);
        check({tag, "_protocol_err"}, 64'(proto_err), 64'd0);
        check({tag, "_timeout"}, 64'(timed_out), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] a;
        logic [31:0] c;
        int          nl;
        line_t       l;
        logic [31:0] exp_swap;

        vecs[0] = '{64'h1000, 32'd4,  1'b0, 1};
        vecs[1] = '{64'h1078, 32'd5,  1'b0, 2};
        vecs[2] = '{64'h1000, 32'd0,  1'b0, 0};
        vecs[3] = '{64'h107C, 32'd1,  1'b0, 1};
        vecs[4] = '{64'h1004, 32'd31, 1'b0, 1};
        vecs[5] = '{64'h1004, 32'd32, 1'b1, 2};
        vecs[6] = '{64'h1003, 32'd33, 1'b1, 2};
        vecs[7] = '{64'h2040, 32'd64, 1'b1, 3};

        bus.job_valid = 0; bus.job_start_addr = '0; bus.job_edge_count = '0;
        bus.line_valid = 0; bus.line_data = '0; bus.edge_ready = 0;
        rand_ready = 0;

        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs",
              64'({bus.job_ready, bus.line_ready, bus.edge_valid, bus.edge_id,
                   bus.edge_last, bus.job_done, bus.busy}), 64'd0);
        reset = 0;

        for (int v = 0; v < 8; v++) begin
            make_lines(vecs[v].exp_lines + 1, 1'b1);
            rand_ready = vecs[v].rnd;
            run_job(vecs[v].addr, vecs[v].cnt, 0);
            check_job($sformatf("vec%0d", v), vecs[v].addr, vecs[v].cnt, vecs[v].exp_lines);
        end
        rand_ready = 0;

        // Aligned single line: consecutive edges, done right after the last one.
        make_lines(2, 1'b1);
        run_job(64'h1000, 32'd4, 0);
        check_job("aligned", 64'h1000, 32'd4, 1);
        if (got_cyc.size() == 4) begin
            check("aligned_back_to_back", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
            check("aligned_done_timing", 64'(done_cyc), 64'(got_cyc[3] + 1));
            check("aligned_first_id", 64'(got_id[0]), 64'(model_edge(0, 0)));
        end

        // Offset crossing: one bubble at the line boundary.
        make_lines(3, 1'b1);
        run_job(64'h1078, 32'd5, 0);
        check_job("cross", 64'h1078, 32'd5, 2);
        if (got_cyc.size() == 5) begin
            check("cross_b2b", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
            check("cross_bubble", 64'(got_cyc[2] - got_cyc[1] >= 2), 64'd1);
        end

        // Zero count: no line or edge activity, done next cycle, job_ready the cycle after.
        make_lines(1, 1'b1);
        run_job(64'h1000, 32'd0, 0);
        check_job("zero", 64'h1000, 32'd0, 0);
        check("zero_done_timing", 64'(done_cyc), 64'(acc_cyc + 1));
        check("zero_no_activity", 64'(ev_seen + lr_seen), 64'd0);
        @(negedge clock); #1;
        check("zero_job_ready_after", 64'(bus.job_ready), 64'd1);

        // Backpressure with a fixed ready pattern while edges are offered.
        make_lines(2, 1'b1);
        ready_pat = '{0, 0, 1, 0, 1, 1};
        run_job(64'h1000, 32'd3, 0);
        check_job("bp", 64'h1000, 32'd3, 1);
        check("bp_stall_cycles", 64'(ev_seen), 64'd6);
        ready_pat.delete();

        // Byte-swap behaviour on a single edge.
        make_lines(2, 1'b0);
        l = lines[0];
        l[31:0] = 32'hAABBCCDD;
        lines[0] = l;
`ifdef EDGE_UNPACK_BYTE_SWAP_EN
        exp_swap = 32'hDDCCBBAA;
`else
        exp_swap = 32'hAABBCCDD;
`endif
        run_job(64'h2000, 32'd1, 0);
        check_job("swap", 64'h2000, 32'd1, 1);
        if (got_id.size() == 1) check("swap_value", 64'(got_id[0]), 64'(exp_swap));

        // Reset mid-job, then a fresh single-edge job.
        make_lines(3, 1'b1);
        run_job(64'h0, 32'd64, 10);
        check("midrst_edges_before", 64'(got_id.size()), 64'd10);
        reset = 1;
        #1;
        check("midrst_outputs",
              64'({bus.job_ready, bus.line_ready, bus.edge_valid, bus.edge_id,
                   bus.edge_last, bus.job_done, bus.busy}), 64'd0);
        @(negedge clock);
        reset = 0;
        make_lines(2, 1'b0);
        run_job(64'h40, 32'd1, 0);
        check_job("postrst", 64'h40, 32'd1, 1);

        // Random jobs.
        rand_ready = 1;
        for (int r = 0; r < 20; r++) begin
            a  = {$urandom, $urandom};
            c  = 32'($urandom_range(0, 100));
            nl = (c == 0) ? 0 : (int'(a[6:2]) + int'(c) + 31) / 32;
            make_lines(nl + 1, 1'b0);
            run_job(a, c, 0);
            check_job($sformatf("rnd%0d", r), a, c, nl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
